branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor. It is the consumer of the execute-stage branch comparator's br_en result.
- Holds a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB).
- Fetch queries it every cycle with the current PC. Execute writes each resolved conditional branch back (br_en, computed target, what fetch predicted).
- Also keeps branch and mispredict performance counters.

Parameters:
- IDX_W, default 6, index width; table depth is 2**IDX_W entries. Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  synchronous reset, active low
- ready  output  1  high once table initialisation is complete
- pred_pc  input  32  fetch PC being predicted
- pred_taken  output  1  predict taken
- pred_target  output  32  predicted next PC
- upd_valid  input  1  resolved conditional branch present this cycle
- upd_pc  input  32  PC of resolved branch
- upd_br_en  input  1  actual outcome from comparator
- upd_target  input  32  actual taken target
- upd_pred_taken  input  1  prediction fetch made for this branch
- upd_pred_target  input  32  target fetch predicted
- branch_count  output  32  resolved branches counted
- mispredict_count  output  32  mispredicted branches counted

Behaviour:
- Per entry: cnt[1:0], valid, tag, target[31:0].
  - Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Reset: when rst_n=0 at a clock edge:
  - state<=INIT, init_idx<=0, ready<=0, branch_count<=0, mispredict_count<=0.
  - Reset asserted mid-operation (INIT or RUN) restarts the sweep.
- INIT state:
  - Each cycle writes entry init_idx: cnt=01, valid=0. Then init_idx increments.
  - After writing entry 2**IDX_W-1, state<=RUN and ready<=1.
  - With rst_n released at edge 0, ready is high from edge 2**IDX_W onward: 64 cycles for the default.
  - Updates during INIT are ignored and not counted.
- Prediction is combinational from registered table state; no pipeline latency.
  - hit = valid[idx] && tag[idx]==pred_pc tag.
  - pred_taken = ready && hit && cnt[idx][1].
  - pred_target = pred_taken ? target[idx] : pred_pc+4. Addition wraps modulo 2**32.
  - While ready=0: pred_taken=0, pred_target=pred_pc+4.
- Update (RUN, upd_valid=1), applied at the clock edge, to entry at upd_pc index:
  - Counter: saturating +1 if upd_br_en, -1 otherwise. 11 stays 11; 00 stays 00.
  - If tag mismatches or valid=0, the entry is reallocated first: cnt reset to 01, then the step applied. Result: 10 if taken, 00 if not.
  - If upd_br_en: valid<=1, tag<=upd_pc tag, target<=upd_target.
  - If not taken: tag/target/valid unchanged, except that a reallocation leaves valid=0.
- Counters:
  - branch_count increments once per RUN update.
  - mispredict_count increments when upd_pred_taken!=upd_br_en, or when both are 1 and upd_pred_target!=upd_target.
  - Both counters saturate at 32'hFFFF_FFFF; no wrap.
- Same-cycle predict and update to the same index: prediction uses the pre-update value; no bypass. The new value is visible the next cycle.
- upd_valid with X on other inputs while ready=0 has no effect.
- Unused pc[1:0] bits are ignored.

Test Plan:
- Init: hold rst_n=0 for 2 cycles, release -> ready=0 for exactly 64 cycles then 1. pred_pc=0x100 gives pred_taken=0, pred_target=0x104. Both counts 0.
- Train taken: update pc=0x100, br_en=1, target=0x80, pred_taken=0 -> next cycle pred_pc=0x100 gives taken, target 0x80. branch_count=1, mispredict_count=1.
- Hysteresis: three taken updates on 0x100 (cnt=11), then one not-taken -> still predicts taken. Second not-taken -> pred_taken=0, pred_target=0x104.
- Alias: after training 0x100 taken, query 0x200 (same index 0, different tag) -> not taken. Taken update on 0x200 target 0x300 -> 0x200 predicts 0x300 and 0x100 now predicts not taken.
- Target mismatch: upd_pred_taken=1, upd_br_en=1, upd_pred_target=0x80, upd_target=0x90 -> mispredict_count+1 and entry target becomes 0x90. Same-cycle query of that PC returns 0x80, next cycle 0x90.
- Reset mid-RUN: trained entries, pulse rst_n low one cycle -> ready drops, counts zero, after 64 cycles all PCs predict not taken.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit saturating counters with a
// tagged branch target buffer, plus resolved-branch / mispredict counters.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ready,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_br_en,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] init_idx, init_idx_next;
  logic             ready_next;

  logic [1:0]       cnt_q    [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q    [DEPTH];
  logic [31:0]      target_q [DEPTH];

  logic [IDX_W-1:0] pred_idx, upd_idx;
  logic [TAG_W-1:0] pred_tag, upd_tag;
  logic             pred_hit;
  logic             upd_en, realloc, mispredict;
  logic [1:0]       cnt_base, cnt_new;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{pred_pc[1:0], upd_pc[1:0]};

  // Prediction reads registered table state only, so a same-cycle update is not bypassed.
  assign pred_idx    = pred_pc[IDX_W+1:2];
  assign pred_tag    = pred_pc[31:IDX_W+2];
  assign pred_hit    = valid_q[pred_idx] && (tag_q[pred_idx] == pred_tag);
  assign pred_taken  = ready && pred_hit && cnt_q[pred_idx][1];
  assign pred_target = pred_taken ? target_q[pred_idx] : pred_pc + 32'd4;

  assign upd_idx    = upd_pc[IDX_W+1:2];
  assign upd_tag    = upd_pc[31:IDX_W+2];
  assign upd_en     = (state == RUN) && upd_valid;
  assign realloc    = !valid_q[upd_idx] || (tag_q[upd_idx] != upd_tag);
  assign mispredict = (upd_pred_taken != upd_br_en) ||
                      (upd_pred_taken && upd_br_en && (upd_pred_target != upd_target));

  // A reallocated entry restarts from weakly-not-taken before the step.
  always_comb begin
    cnt_base = realloc ? 2'b01 : cnt_q[upd_idx];
    cnt_new  = cnt_base;
    if (upd_br_en) begin
      if (cnt_base != 2'b11) cnt_new = cnt_base + 2'b01;
    end else begin
      if (cnt_base != 2'b00) cnt_new = cnt_base - 2'b01;
    end
  end

  always_comb begin
    state_next    = state;
    init_idx_next = init_idx;
    ready_next    = ready;
    if (state == INIT) begin
      init_idx_next = init_idx + 1'b1;
      if (&init_idx) begin
        state_next = RUN;
        ready_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= INIT;
      init_idx         <= '0;
      ready            <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      state    <= state_next;
      init_idx <= init_idx_next;
      ready    <= ready_next;
      if (upd_en) begin
        if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
        if (mispredict && (mispredict_count != 32'hFFFF_FFFF))
          mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

  // Table contents are not reset directly; the INIT sweep clears them one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        cnt_q[init_idx]   <= 2'b01;
        valid_q[init_idx] <= 1'b0;
      end else if (upd_valid) begin
        cnt_q[upd_idx] <= cnt_new;
        if (upd_br_en) begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
        end else if (realloc) begin
          valid_q[upd_idx] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: scenario tasks with a prediction
// scoreboard queue and inline count checks.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_br_en;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs, exp_v;

  branch_predictor #(.IDX_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_en(upd_br_en),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus after the falling edge; the update lands on the next rising edge.
  task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ben, input logic [31:0] utgt,
                       input logic upt, input logic [31:0] uptgt);
    @(negedge clk);
    pred_pc = pc; upd_valid = uv; upd_pc = upc; upd_br_en = ben;
    upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
    #1;
  endtask

  task automatic expect_pred(input logic t, input logic [31:0] tgt);
    exp_q.push_back({t, tgt});
  endtask

  task automatic wait_ready(output int low_cycles);
    low_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      if (ready) break;
      low_cycles++;
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    int low;
    rst_n = 1'b0; upd_valid = 1'b0; pred_pc = 32'h0;
    upd_pc = 32'h0; upd_br_en = 1'b0; upd_target = 32'h0;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pred_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h100; upd_br_en = 1'b1; upd_target = 32'h80;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h104;
    #1;
    expect_pred(1'b0, 32'h104);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL init_pred: got %h expected %h", obs, exp_v); end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL init_ready_low: got %b expected 0", ready); end
    wait_ready(low);
    upd_valid = 1'b0;
    checks++;
    if (low != 64) begin errors++; $display("FAIL init_latency: got %0d expected 64", low); end
    checks++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      errors++; $display("FAIL init_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    end
  endtask

  task automatic test_train_taken();
    drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    expect_pred(1'b0, 32'h104);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL train_before: got %h expected %h", obs, exp_v); end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b1, 32'h80);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL train_after: got %h expected %h", obs, exp_v); end
    checks++;
    if (branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
      errors++; $display("FAIL train_counts: got %0d/%0d expected 1/1", branch_count, mispredict_count);
    end
  endtask

  task automatic test_hysteresis();
    for (int i = 0; i < 3; i++) begin
      drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80);
      expect_pred(1'b1, 32'h80);
      obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL hyst_taken_%0d: got %h expected %h", i, obs, exp_v); end
    end
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
    expect_pred(1'b1, 32'h80);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hyst_one_nt: got %h expected %h", obs, exp_v); end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b0, 32'h104);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL hyst_two_nt: got %h expected %h", obs, exp_v); end
    checks++;
    if (branch_count !== 32'd6 || mispredict_count !== 32'd3) begin
      errors++; $display("FAIL hyst_counts: got %0d/%0d expected 6/3", branch_count, mispredict_count);
    end
  endtask

  task automatic test_alias();
    repeat (2) drive(32'h0, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b1, 32'h80);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL alias_retrain: got %h expected %h", obs, exp_v); end
    drive(32'h200, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h204);
    expect_pred(1'b0, 32'h204);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL alias_miss: got %h expected %h", obs, exp_v); end
    drive(32'h200, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b1, 32'h300);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL alias_new: got %h expected %h", obs, exp_v); end
    drive(32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b0, 32'h104);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL alias_evicted: got %h expected %h", obs, exp_v); end
    checks++;
    if (branch_count !== 32'd9 || mispredict_count !== 32'd6) begin
      errors++; $display("FAIL alias_counts: got %0d/%0d expected 9/6", branch_count, mispredict_count);
    end
  endtask

  task automatic test_target_mismatch();
    drive(32'h0, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44);
    drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h90, 1'b1, 32'h80);
    expect_pred(1'b1, 32'h80);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tgt_same_cycle: got %h expected %h", obs, exp_v); end
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b1, 32'h90);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tgt_next_cycle: got %h expected %h", obs, exp_v); end
    drive(32'h42, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b1, 32'h90);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL tgt_low_bits: got %h expected %h", obs, exp_v); end
    checks++;
    if (branch_count !== 32'd11 || mispredict_count !== 32'd8) begin
      errors++; $display("FAIL tgt_counts: got %0d/%0d expected 11/8", branch_count, mispredict_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rnd_tgt;
    rnd_tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    // Not-taken update with a foreign tag evicts the entry at index 16.
    drive(32'h0, 1'b1, 32'h240, 1'b0, rnd_tgt, 1'b0, 32'h244);
    drive(32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b0, 32'h44);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL nt_realloc: got %h expected %h", obs, exp_v); end
    drive(32'h380, 1'b1, 32'h380, 1'b1, rnd_tgt, 1'b0, 32'h384);
    drive(32'h380, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b1, rnd_tgt);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL rand_target: got %h expected %h", obs, exp_v); end
    drive(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred(1'b0, 32'h0);
    obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL pc_wrap: got %h expected %h", obs, exp_v); end
    checks++;
    if (branch_count !== 32'd13 || mispredict_count !== 32'd9) begin
      errors++; $display("FAIL b2b_counts: got %0d/%0d expected 13/9", branch_count, mispredict_count);
    end
  endtask

  task automatic test_mid_reset();
    int low;
    @(negedge clk);
    rst_n = 1'b0;
    upd_valid = 1'b1; upd_pc = 32'h300; upd_br_en = 1'b1; upd_target = 32'h500;
    upd_pred_taken = 1'b0; upd_pred_target = 32'h304;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b0 || branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      errors++; $display("FAIL rst_state: got ready=%b counts %0d/%0d expected 0 0/0",
                         ready, branch_count, mispredict_count);
    end
    wait_ready(low);
    upd_valid = 1'b0;
    checks++;
    if (low != 64) begin errors++; $display("FAIL rst_latency: got %0d expected 64", low); end
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pcs [4];
      pcs = '{32'h100, 32'h200, 32'h40, 32'h380};
      drive(pcs[i], 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      expect_pred(1'b0, pcs[i] + 32'd4);
      obs = {pred_taken, pred_target}; exp_v = exp_q.pop_front(); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_cleared_%0d: got %h expected %h", i, obs, exp_v); end
    end
    checks++;
    if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
      errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", branch_count, mispredict_count);
    end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_hysteresis();
    test_alias();
    test_target_mismatch();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL queue_drained: got %0d expected 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
